// File: rtl/lector_muestras_circular.sv
// Circular tap-sample store for the FIR datapath. Streams the last NUM_TAPS samples newest-first
// over valid/ready; writes during a burst park in a 1-deep holding register.
//
// state   | meaning
// REPOSO  | idle: writes go to the buffer, a pending request may start a burst
// LECTURA | burst in progress: one snapshot streamed, new writes parked in holding
module lector_muestras_circular #(
  parameter int ANCHO_DATOS  = 16,
  parameter int NUM_TAPS     = 8,
  parameter int ANCHO_INDICE = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    habilitador,
  input  logic [ANCHO_DATOS-1:0]  datos_entrada,
  input  logic                    inicio,
  input  logic                    listo,
  output logic [ANCHO_DATOS-1:0]  muestra_salida,
  output logic [ANCHO_INDICE-1:0] indice_tap,
  output logic                    valido,
  output logic                    ultimo,
  output logic                    ocupado,
  output logic                    desborde
);

  typedef enum logic {REPOSO = 1'b0, LECTURA = 1'b1} estado_t;

  localparam logic [ANCHO_INDICE-1:0] IDX_MAX = ANCHO_INDICE'(NUM_TAPS - 1);
  localparam logic [ANCHO_INDICE-1:0] UNO     = ANCHO_INDICE'(1);

  estado_t estado, estado_sig;

  logic [ANCHO_DATOS-1:0]  mem [NUM_TAPS];
  logic [ANCHO_INDICE-1:0] ptr, rd_ptr;
  logic [ANCHO_DATOS-1:0]  retencion;
  logic                    pendiente, solicitud;
  logic                    transfer, fin_rafaga, arranque, ventana_escritura, escribe_mem;
  logic [ANCHO_DATOS-1:0]  dato_mem;

  function automatic logic [ANCHO_INDICE-1:0] anterior(input logic [ANCHO_INDICE-1:0] p);
    return (p == '0) ? IDX_MAX : p - UNO;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    transfer   = 1'b0;
    fin_rafaga = 1'b0;
    arranque   = 1'b0;
    case (estado)
      REPOSO: begin
        if ((inicio || solicitud) && !pendiente && !habilitador) begin
          arranque   = 1'b1;
          estado_sig = LECTURA;
        end
      end
      LECTURA: begin
        transfer = listo;
        if (listo && indice_tap == IDX_MAX) begin
          fin_rafaga = 1'b1;
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
    // Buffer may only change outside a burst or on its closing edge, keeping the snapshot stable
    ventana_escritura = (estado == REPOSO) || fin_rafaga;
    escribe_mem       = ventana_escritura && (pendiente || habilitador);
    dato_mem          = pendiente ? retencion : datos_entrada;
  end

  assign valido  = (estado == LECTURA);
  assign ocupado = (estado == LECTURA);
  assign ultimo  = valido && (indice_tap == IDX_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
      ptr            <= '0;
      rd_ptr         <= '0;
      retencion      <= '0;
      pendiente      <= 1'b0;
      solicitud      <= 1'b0;
      desborde       <= 1'b0;
      muestra_salida <= '0;
      indice_tap     <= '0;
    end else begin
      if (escribe_mem) begin
        mem[ptr] <= dato_mem;
        ptr      <= (ptr == IDX_MAX) ? '0 : ptr + UNO;
      end

      if (ventana_escritura) begin
        // A held sample commits this edge; a concurrent write takes its place in holding
        if (pendiente && habilitador) retencion <= datos_entrada;
        pendiente <= pendiente && habilitador;
      end else if (habilitador) begin
        retencion <= datos_entrada;
        pendiente <= 1'b1;
        if (pendiente) desborde <= 1'b1;
      end

      if (arranque)    solicitud <= 1'b0;
      else if (inicio) solicitud <= 1'b1;

      if (arranque) begin
        rd_ptr         <= anterior(ptr);
        muestra_salida <= mem[anterior(ptr)];
        indice_tap     <= '0;
      end else if (transfer && !fin_rafaga) begin
        rd_ptr         <= anterior(rd_ptr);
        muestra_salida <= mem[anterior(rd_ptr)];
        indice_tap     <= indice_tap + UNO;
      end
    end
  end

endmodule

// File: tb/tb_lector_muestras_circular.sv
// Scoreboard bench for lector_muestras_circular (8-bit samples, 4 taps): directed stimulus
// pushes expected transfers, a negedge monitor pops and compares them.
module tb_lector_muestras_circular;

  localparam int AD = 8;
  localparam int NT = 4;
  localparam int AI = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          habilitador = 1'b0;
  logic [AD-1:0] datos_entrada = '0;
  logic          inicio = 1'b0;
  logic          listo = 1'b0;
  logic [AD-1:0] muestra_salida;
  logic [AI-1:0] indice_tap;
  logic          valido, ultimo, ocupado, desborde;

  typedef struct packed {
    logic [AD-1:0] d;
    logic [AI-1:0] idx;
    logic          ult;
  } esperado_t;

  esperado_t cola[$];
  int tests = 0;
  int fails = 0;

  lector_muestras_circular #(.ANCHO_DATOS(AD), .NUM_TAPS(NT), .ANCHO_INDICE(AI)) dut (
    .clk(clk), .reset(reset), .habilitador(habilitador), .datos_entrada(datos_entrada),
    .inicio(inicio), .listo(listo), .muestra_salida(muestra_salida), .indice_tap(indice_tap),
    .valido(valido), .ultimo(ultimo), .ocupado(ocupado), .desborde(desborde)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted transfer must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && valido && listo) begin
      tests++;
      if (cola.size() == 0) begin
        fails++;
        $display("FAIL sb_inesperado: got d=%0h idx=%0d ult=%0b, expected no transfer",
                 muestra_salida, indice_tap, ultimo);
      end else begin
        esperado_t e;
        e = cola.pop_front();
        if (muestra_salida !== e.d || indice_tap !== e.idx || ultimo !== e.ult) begin
          fails++;
          $display("FAIL sb_transfer: got d=%0h idx=%0d ult=%0b, expected d=%0h idx=%0d ult=%0b",
                   muestra_salida, indice_tap, ultimo, e.d, e.idx, e.ult);
        end
      end
    end
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic escribir(input logic [AD-1:0] d);
    habilitador   = 1'b1;
    datos_entrada = d;
    tick();
    habilitador   = 1'b0;
  endtask

  task automatic pulso_inicio();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic push_rafaga(input logic [AD-1:0] d0, input logic [AD-1:0] d1,
                             input logic [AD-1:0] d2, input logic [AD-1:0] d3);
    cola.push_back('{d: d0, idx: 2'd0, ult: 1'b0});
    cola.push_back('{d: d1, idx: 2'd1, ult: 1'b0});
    cola.push_back('{d: d2, idx: 2'd2, ult: 1'b0});
    cola.push_back('{d: d3, idx: 2'd3, ult: 1'b1});
  endtask

  // Waits (bounded) for a burst to begin and then to end; reports both durations
  task automatic esperar_rafaga(output int espera, output int ciclos);
    espera = 0;
    ciclos = 0;
    while (!ocupado && espera < 20) begin tick(); espera++; end
    if (!ocupado) begin
      tests++; fails++;
      $display("FAIL timeout_inicio: got ocupado=0 expected 1 within 20 cycles");
    end
    while (ocupado && ciclos < 40) begin tick(); ciclos++; end
    if (ocupado) begin
      tests++; fails++;
      $display("FAIL timeout_fin: got ocupado=1 expected 0 within 40 cycles");
    end
  endtask

  task automatic chk_todo_cero(input string nombre);
    chk({nombre, "_muestra"}, 32'(muestra_salida), 32'h0);
    chk({nombre, "_ctrl"}, {26'b0, indice_tap, valido, ultimo, ocupado, desborde}, 32'h0);
  endtask

  initial begin
    int espera, ciclos;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_todo_cero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Empty buffer burst
    listo = 1'b1;
    push_rafaga(8'h00, 8'h00, 8'h00, 8'h00);
    pulso_inicio();
    chk("latencia_valido", 32'(valido), 32'h1);
    chk("latencia_idx0", 32'(indice_tap), 32'h0);
    esperar_rafaga(espera, ciclos);
    chk("vacia_ciclos", 32'(ciclos), 32'd4);
    chk("vacia_ocupado", 32'(ocupado), 32'h0);
    chk("vacia_sb", 32'(cola.size()), 32'h0);

    // 5 writes wrap the 4-deep buffer
    escribir(8'h11); escribir(8'h22); escribir(8'h33); escribir(8'h44); escribir(8'h55);
    push_rafaga(8'h55, 8'h44, 8'h33, 8'h22);
    pulso_inicio();
    esperar_rafaga(espera, ciclos);
    chk("wrap_ciclos", 32'(ciclos), 32'd4);
    chk("wrap_sb", 32'(cola.size()), 32'h0);

    // Back-pressure at tap 1
    push_rafaga(8'h55, 8'h44, 8'h33, 8'h22);
    pulso_inicio();
    tick();
    listo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_dato", 32'(muestra_salida), 32'h44);
      chk("hold_idx", 32'(indice_tap), 32'h1);
      chk("hold_valido", 32'(valido), 32'h1);
      if (i < 2) tick();
    end
    listo = 1'b1;
    esperar_rafaga(espera, ciclos);
    chk("hold_sb", 32'(cola.size()), 32'h0);

    // Single write mid-burst goes to holding and commits at burst end
    push_rafaga(8'h55, 8'h44, 8'h33, 8'h22);
    pulso_inicio();
    tick();
    tick();
    chk("medio_idx2", 32'(indice_tap), 32'h2);
    escribir(8'h66);
    esperar_rafaga(espera, ciclos);
    chk("medio_desborde", 32'(desborde), 32'h0);
    push_rafaga(8'h66, 8'h55, 8'h44, 8'h33);
    pulso_inicio();
    esperar_rafaga(espera, ciclos);
    chk("medio_sb", 32'(cola.size()), 32'h0);

    // Two writes in one burst: newest wins, overflow sticks
    push_rafaga(8'h66, 8'h55, 8'h44, 8'h33);
    pulso_inicio();
    escribir(8'h66);
    escribir(8'h77);
    esperar_rafaga(espera, ciclos);
    chk("desborde_set", 32'(desborde), 32'h1);
    push_rafaga(8'h77, 8'h66, 8'h55, 8'h44);
    pulso_inicio();
    esperar_rafaga(espera, ciclos);
    chk("desborde_sticky", 32'(desborde), 32'h1);
    chk("desborde_sb", 32'(cola.size()), 32'h0);

    // inicio together with a write: start deferred one cycle, new sample is tap 0
    push_rafaga(8'h88, 8'h77, 8'h66, 8'h55);
    habilitador   = 1'b1;
    datos_entrada = 8'h88;
    inicio        = 1'b1;
    tick();
    habilitador = 1'b0;
    inicio      = 1'b0;
    chk("diferido_valido0", 32'(valido), 32'h0);
    tick();
    chk("diferido_valido1", 32'(valido), 32'h1);
    chk("diferido_dato", 32'(muestra_salida), 32'h88);
    tick();
    push_rafaga(8'h88, 8'h77, 8'h66, 8'h55);
    pulso_inicio();
    esperar_rafaga(espera, ciclos);
    esperar_rafaga(espera, ciclos);
    chk("b2b_espera", 32'(espera), 32'd1);
    chk("b2b_ciclos", 32'(ciclos), 32'd4);
    chk("b2b_sb", 32'(cola.size()), 32'h0);

    // Reset mid-burst at tap 2
    cola.push_back('{d: 8'h88, idx: 2'd0, ult: 1'b0});
    cola.push_back('{d: 8'h77, idx: 2'd1, ult: 1'b0});
    pulso_inicio();
    tick();
    tick();
    chk("abort_idx2", 32'(indice_tap), 32'h2);
    reset = 1'b0;
    #1;
    chk_todo_cero("abort");
    chk("abort_sb", 32'(cola.size()), 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    push_rafaga(8'h00, 8'h00, 8'h00, 8'h00);
    pulso_inicio();
    esperar_rafaga(espera, ciclos);
    chk("post_reset_sb", 32'(cola.size()), 32'h0);
    chk("post_reset_desborde", 32'(desborde), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
